// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
//   arb_state_t : access sequencer states (IDLE, ACCESS, CAPTURE, RESP)
//   req_id_t    : requester identity (REQ_IFU, REQ_LSU)
//   ALIGN_BITS  : address bits below the RAM word for the default 64-bit data path
//   IDLE_ADDR_DEF : parked read address; must map to real RAM because the RAM
//                   model evaluates raddr on every clock edge.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

  localparam int          DATA_W_DEF    = 64;
  localparam int          ALIGN_BITS    = $clog2(DATA_W_DEF / 8);
  localparam logic [63:0] IDLE_ADDR_DEF = 64'h8000_0000;

endpackage

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2: two-way round-robin grant.
//   clock, reset : clock and synchronous active-high reset
//   ifu_valid    : IFU is requesting
//   lsu_valid    : LSU is requesting
//   update       : a grant was consumed this cycle; remember who won
//   grant        : one-hot grant, bit 0 = IFU, bit 1 = LSU (zero when nobody asks)
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       update,
  output logic [1:0] grant
);

  req_id_t last_grant_reg;

  // Starting from IFU means the LSU wins the first tie after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= REQ_IFU;
    end else if (update && (grant != 2'b00)) begin
      last_grant_reg <= grant[1] ? REQ_LSU : REQ_IFU;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      grant = (last_grant_reg == REQ_IFU) ? 2'b10 : 2'b01;
    end else if (ifu_valid) begin
      grant = 2'b01;
    end else if (lsu_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAMCtrl access port between the IFU (read only)
// and the LSU (read/write). Every accepted request runs a fixed sequence
// IDLE -> ACCESS -> CAPTURE -> RESP, so the RAM sees at most one write strobe
// per accepted store.
//   clock, reset          : clock and synchronous active-high reset
//   ifu_req_*             : IFU fetch request (valid/ready, addr)
//   ifu_resp_*            : IFU fetch response (valid/ready, data)
//   lsu_req_*             : LSU request (valid/ready, addr, wen, wdata, wstrb)
//   lsu_resp_*            : LSU response (valid/ready, data; 0 for stores)
//   ram_raddr/ram_rdata   : RAMCtrl read port (rdata valid the cycle after raddr is sampled)
//   ram_waddr/wdata/wstrb/wen : RAMCtrl write port
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(IDLE_ADDR_DEF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic [ADDR_W-1:0]   ram_raddr,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic                ram_wen
);

  localparam int                STRB_W     = DATA_W / 8;
  localparam int                AL_BITS    = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << AL_BITS) - ADDR_W'(1));

  arb_state_t          state_reg, state_next;
  req_id_t             owner_reg;
  logic [ADDR_W-1:0]   ram_addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic [DATA_W-1:0]   data_reg;

  logic [1:0] grant;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic       req_hs;
  logic       resp_hs;
  logic       sel_lsu;

  assign req_valid  = {lsu_req_valid, ifu_req_valid};
  assign resp_ready = {lsu_resp_ready, ifu_resp_ready};

  // Requests are only consumed in IDLE; the grant is always one-hot when any
  // valid is present, so a handshake happens whenever someone asks in IDLE.
  assign req_hs  = (state_reg == IDLE) && (|req_valid);
  assign sel_lsu = grant[1];

  ram_arb_rr2 u_rr2 (
    .clock     (clock),
    .reset     (reset),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .update    (req_hs),
    .grant     (grant)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi]  = (state_reg == IDLE) && grant[gi];
    assign resp_valid[gi] = (state_reg == RESP) &&
                            (owner_reg == ((gi == 1) ? REQ_LSU : REQ_IFU));
  end

  assign resp_hs = |(resp_valid & resp_ready);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_hs) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (resp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and read-data capture. ram_addr_reg is loaded with the
  // word-aligned address at handshake, so it drives the RAM during ACCESS and
  // simply parks on that address afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_reg    <= REQ_IFU;
      ram_addr_reg <= IDLE_ADDR;
      wen_reg      <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      data_reg     <= '0;
    end else begin
      if (req_hs) begin
        owner_reg    <= sel_lsu ? REQ_LSU : REQ_IFU;
        ram_addr_reg <= (sel_lsu ? lsu_req_addr : ifu_req_addr) & ALIGN_MASK;
        wen_reg      <= sel_lsu && lsu_req_wen;
        wdata_reg    <= sel_lsu ? lsu_req_wdata : '0;
        wstrb_reg    <= sel_lsu ? lsu_req_wstrb : '0;
      end
      // rdata reflects the address sampled at the end of ACCESS.
      if (state_reg == CAPTURE) begin
        data_reg <= wen_reg ? '0 : ram_rdata;
      end
    end
  end

  // Outputs. ram_wen is gated with reset so a reset landing in ACCESS
  // cannot leak a write into the RAM.
  always_comb begin
    ram_wen        = 1'b0;
    ram_wstrb      = '0;
    ram_raddr      = ram_addr_reg;
    ram_waddr      = ram_addr_reg;
    ram_wdata      = wdata_reg;
    ifu_req_ready  = req_ready[0];
    lsu_req_ready  = req_ready[1];
    ifu_resp_valid = resp_valid[0];
    lsu_resp_valid = resp_valid[1];
    ifu_resp_data  = data_reg;
    lsu_resp_data  = data_reg;
    if (state_reg == ACCESS) begin
      ram_wstrb = wstrb_reg;
      ram_wen   = (owner_reg == REQ_LSU) && wen_reg && !reset;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam logic [63:0] IDLE_A = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wstrb;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [63:0] lsu_resp_data;
  logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic [7:0]  ram_wstrb;
  logic        ram_wen;

  ram_port_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wstrb  (lsu_req_wstrb),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_resp_data  (lsu_resp_data),
    .ram_raddr      (ram_raddr),
    .ram_rdata      (ram_rdata),
    .ram_waddr      (ram_waddr),
    .ram_wdata      (ram_wdata),
    .ram_wstrb      (ram_wstrb),
    .ram_wen        (ram_wen)
  );

  always #5 clock = ~clock;

  // RAMCtrl stand-in: samples raddr/wen at the edge, rdata valid the next cycle.
  logic [63:0] dev_mem [longint unsigned];
  logic [63:0] dev_w;
  always @(posedge clock) begin
    ram_rdata <= dev_mem.exists(ram_raddr >> 3) ? dev_mem[ram_raddr >> 3] : 64'h0;
    if (ram_wen === 1'b1) begin
      dev_w = dev_mem.exists(ram_waddr >> 3) ? dev_mem[ram_waddr >> 3] : 64'h0;
      for (int i = 0; i < 8; i++)
        if (ram_wstrb[i]) dev_w[8*i +: 8] = ram_wdata[8*i +: 8];
      dev_mem[ram_waddr >> 3] = dev_w;
    end
  end

  // Count every cycle the RAM write strobe is high.
  int wen_pulses = 0;
  always @(negedge clock) if (ram_wen === 1'b1) wen_pulses++;

  // Reference model: byte-addressed memory and transaction-level state.
  logic [7:0]  ref_mem [longint unsigned];
  bit          m_last_lsu;
  logic [63:0] m_addr;
  int          exp_stores = 0;
  int          txn = 0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] r = 64'h0;
    for (int i = 0; i < 8; i++)
      if (ref_mem.exists(a + 64'(i))) r[8*i +: 8] = ref_mem[a + 64'(i)];
    return r;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    for (int i = 0; i < 8; i++)
      if (s[i]) ref_mem[a + 64'(i)] = d[8*i +: 8];
  endtask

  // Pending requests, held until granted.
  bit          p_ifu, p_lsu;
  logic [63:0] ifu_a, lsu_a, lsu_d;
  bit          lsu_w;
  logic [7:0]  lsu_s;

  task automatic do_reset();
    ifu_req_valid = 0; lsu_req_valid = 0; p_ifu = 0; p_lsu = 0;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    m_last_lsu = 0;
    m_addr = IDLE_A;
  endtask

  task automatic idle_cycle();
    ifu_req_valid = 0; lsu_req_valid = 0;
    #1;
    check_val("idle_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    check_val("idle_wen", ram_wen, 1'b0);
    check_val("idle_raddr", ram_raddr, m_addr);
    @(negedge clock);
  endtask

  // One full transaction starting from an IDLE cycle (low clock phase).
  task automatic do_round(input int bp, input bit rst_in_access);
    bit          win_lsu, st;
    logic [63:0] a, exp_data;
    ifu_req_valid = p_ifu; ifu_req_addr = ifu_a;
    lsu_req_valid = p_lsu; lsu_req_addr = lsu_a;
    lsu_req_wen = lsu_w; lsu_req_wdata = lsu_d; lsu_req_wstrb = lsu_s;
    #1;
    win_lsu = (p_ifu && p_lsu) ? !m_last_lsu : p_lsu;
    check_val("grant_ifu_ready", ifu_req_ready, !win_lsu);
    check_val("grant_lsu_ready", lsu_req_ready, win_lsu);
    a  = (win_lsu ? lsu_a : ifu_a) & ~64'h7;
    st = win_lsu && lsu_w;
    @(posedge clock);
    m_last_lsu = win_lsu;
    if (rst_in_access) begin
      #1 reset = 1;
    end
    @(negedge clock);
    if (win_lsu) begin lsu_req_valid = 0; p_lsu = 0; end
    else begin ifu_req_valid = 0; p_ifu = 0; end
    #1;
    check_val("acc_raddr", ram_raddr, a);
    check_val("acc_waddr", ram_waddr, a);
    check_val("acc_wen", ram_wen, st && !rst_in_access);
    check_val("acc_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    if (st) begin
      check_val("acc_wstrb", ram_wstrb, lsu_s);
      check_val("acc_wdata", ram_wdata, lsu_d);
    end
    if (rst_in_access) begin
      @(posedge clock);
      @(negedge clock);
      reset = 0;
      m_last_lsu = 0;
      m_addr = IDLE_A;
      #1;
      check_val("rst_raddr", ram_raddr, IDLE_A);
      check_val("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      check_val("rst_wen", ram_wen, 1'b0);
      $display("txn %0d: %s store addr=%h dropped by reset", txn++, win_lsu ? "LSU" : "IFU", a);
      return;
    end
    m_addr = a;
    if (st) begin
      ref_write(a, lsu_d, lsu_s);
      exp_stores++;
      exp_data = 64'h0;
    end else begin
      exp_data = ref_read(a);
    end
    @(negedge clock); #1;
    check_val("cap_wen", ram_wen, 1'b0);
    check_val("cap_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    @(negedge clock);
    // The non-owner's ready is high on purpose: it must not end the response.
    if (win_lsu) ifu_resp_ready = 1; else lsu_resp_ready = 1;
    for (int k = 0; k <= bp; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      check_val("resp_valid", {ifu_resp_valid, lsu_resp_valid}, win_lsu ? 2'b01 : 2'b10);
      check_val("resp_data", win_lsu ? lsu_resp_data : ifu_resp_data, exp_data);
      check_val("resp_ready_hold", {ifu_req_ready, lsu_req_ready}, 2'b00);
    end
    if (win_lsu) lsu_resp_ready = 1; else ifu_resp_ready = 1;
    @(posedge clock);
    @(negedge clock);
    ifu_resp_ready = 0; lsu_resp_ready = 0;
    #1;
    check_val("post_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    $display("txn %0d: %s %s addr=%h data=%h bp=%0d", txn++, win_lsu ? "LSU" : "IFU",
             st ? "store" : "load ", a, exp_data, bp);
  endtask

  initial begin
    reset = 1;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0;
    lsu_req_wdata = 0; lsu_req_wstrb = 0; lsu_resp_ready = 0;
    p_ifu = 0; p_lsu = 0; ifu_a = 0; lsu_a = 0; lsu_d = 0; lsu_w = 0; lsu_s = 0;
    m_last_lsu = 0; m_addr = IDLE_A;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_state_raddr", ram_raddr, IDLE_A);
    check_val("rst_state_waddr", ram_waddr, IDLE_A);
    check_val("rst_state_wdata", ram_wdata, 64'h0);
    check_val("rst_state_wstrb", ram_wstrb, 8'h00);
    check_val("rst_state_wen", ram_wen, 1'b0);
    check_val("rst_state_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    reset = 0;

    // Idle after reset: port parked, no writes.
    repeat (20) idle_cycle();

    // Preloaded word, IFU fetch from an unaligned address.
    dev_mem[IDLE_A >> 3] = 64'h1122334455667788;
    ref_write(IDLE_A, 64'h1122334455667788, 8'hFF);
    p_ifu = 1; ifu_a = 64'h8000_0004;
    do_round(0, 0);

    // LSU store then load back.
    p_lsu = 1; lsu_a = 64'h8000_0010; lsu_w = 1; lsu_d = 64'hDEADBEEF; lsu_s = 8'h0F;
    do_round(0, 0);
    p_lsu = 1; lsu_w = 0;
    do_round(0, 0);

    // Continuous tie after reset: LSU, IFU, LSU, IFU.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      if (!p_ifu) begin p_ifu = 1; ifu_a = 64'h8000_0000 + 64'($urandom_range(0, 31)); end
      if (!p_lsu) begin p_lsu = 1; lsu_a = 64'h8000_0010; lsu_w = 0; end
      do_round(0, 0);
    end

    // Response backpressure with the other side waiting.
    p_ifu = 1; p_lsu = 1; ifu_a = 64'h8000_0008; lsu_a = 64'h8000_0010; lsu_w = 0;
    do_round(5, 0);
    do_round(0, 0);

    // Reset during ACCESS of an LSU store.
    p_lsu = 1; lsu_a = 64'h8000_0018; lsu_w = 1; lsu_d = 64'hCAFE_F00D_1234_5678; lsu_s = 8'hFF;
    do_round(0, 1);
    idle_cycle();

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      if (!p_ifu && ($urandom_range(0, 1) == 1)) begin
        p_ifu = 1; ifu_a = 64'h8000_0000 + 64'($urandom_range(0, 127));
      end
      if (!p_lsu && ($urandom_range(0, 1) == 1)) begin
        p_lsu = 1; lsu_a = 64'h8000_0000 + 64'($urandom_range(0, 127));
        lsu_w = ($urandom_range(0, 1) == 1);
        lsu_d = {$urandom, $urandom};
        lsu_s = 8'($urandom_range(0, 255));
      end
      if (!p_ifu && !p_lsu) idle_cycle();
      else do_round($urandom_range(0, 3), 0);
    end

    idle_cycle();
    check_val("wen_pulse_count", 64'(wen_pulses), 64'(exp_stores));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
